i2c_eeprom_master: RTL and testbench

I2C_EEPROM_MASTER -- requirements
Module: i2c_eeprom_master

---
 rtl/i2c_eeprom_master.sv | 108 ++++++++++
 tb/tb_i2c_eeprom_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_master.sv
// i2c_eeprom_master: AT24Cxx byte-write / random-read I2C master with open-drain SDA.
// Define ACK_CHECK_EN to abort to STOP on any slave NACK and report it on ack_err.
module i2c_eeprom_master #(
  parameter int CLK_DIV = 125,
  parameter logic [2:0] DEV_SEL = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr_rd,
  input  logic [12:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);
`ifdef ACK_CHECK_EN
  localparam logic ACK_CHK = 1'b1;
`else
  localparam logic ACK_CHK = 1'b0;
`endif
  localparam logic [3:0] IDLE = 4'd0, START = 4'd1, CTRL_W = 4'd2, ADDR_H = 4'd3, ADDR_L = 4'd4,
                         WDATA = 4'd5, RSTART = 4'd6, CTRL_R = 4'd7, RDATA = 4'd8, MNACK = 4'd9,
                         STOP = 4'd10, DONE = 4'd11;
  logic [3:0] state, nxt, bitn;
  logic [15:0] cnt;
  logic [1:0] ph;
  logic [7:0] sh, nsh, wd;
  logic [12:0] a;
  logic rd, ackv, nk, tx, end_q, end_bit, last, sda_low;
  logic [7:0] ctrl;
  assign ctrl = {4'b1010, DEV_SEL, 1'b0};
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign tx = state inside {CTRL_W, ADDR_H, ADDR_L, WDATA, CTRL_R};
  assign end_q = busy && cnt == 16'(CLK_DIV - 1);
  assign end_bit = end_q && ph == 2'd3;
  assign last = tx ? bitn == 4'd8 : state == RDATA ? bitn == 4'd7 : 1'b1;
  assign sda = sda_low ? 1'b0 : 1'bz;
  // SCL drops for the first quarter of a repeated start so the slave can release its ACK
  always_comb begin
    scl = (state == IDLE || state == DONE || state == START) ? 1'b1
        : (state == RSTART || state == STOP) ? ph != 2'd0 : ph[1];
    sda_low = (state == START || state == RSTART) ? ph[1]
            : state == STOP ? !ph[1]
            : tx ? bitn != 4'd8 && !sh[7] : 1'b0;
  end
  always_comb begin
    nxt = state == ADDR_L ? (rd ? RSTART : WDATA)
        : (state == WDATA || state == MNACK) ? STOP
        : state == STOP ? DONE : state + 4'd1;
    if (ACK_CHK && tx && ackv) nxt = STOP;
    nsh = nxt == CTRL_W ? ctrl : nxt == ADDR_H ? {3'b000, a[12:8]} : nxt == ADDR_L ? a[7:0]
        : nxt == WDATA ? wd : ctrl | 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ph <= '0;
      bitn <= '0;
      sh <= '0;
      rd <= 1'b0;
      a <= '0;
      wd <= '0;
      ackv <= 1'b0;
      nk <= 1'b0;
      ack_err <= 1'b0;
      rdata <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        state <= START;
        rd <= wr_rd;
        a <= addr;
        wd <= wdata;
        cnt <= '0;
        ph <= '0;
        bitn <= '0;
        nk <= 1'b0;
        ack_err <= 1'b0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end else begin
      cnt <= end_q ? '0 : cnt + 16'd1;
      if (end_q) ph <= ph + 2'd1;
      if (end_q && ph == 2'd2) begin
        ackv <= sda;
        if (tx && bitn == 4'd8 && sda) nk <= 1'b1;
        if (state == RDATA) sh <= {sh[6:0], sda};
      end
      if (end_bit && !last) begin
        bitn <= bitn + 4'd1;
        if (tx) sh <= sh << 1;
      end
      if (end_bit && last) begin
        state <= nxt;
        bitn <= '0;
        sh <= nsh;
        if (state == RDATA) rdata <= sh;
        if (state == STOP) ack_err <= ACK_CHK & nk;
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_master.sv
// tb_i2c_eeprom_master: scoreboard bench with a behavioural AT24C64 slave on the I2C bus.
module tb_i2c_eeprom_master;
  localparam int CLK_DIV = 4;
  localparam int BIT = 4 * CLK_DIV;
  logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, wr_rd = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0] wdata = '0;
  logic busy, done, ack_err, scl;
  logic [7:0] rdata;
  wire sda;
  int checks = 0, errors = 0;

  i2c_eeprom_master #(.CLK_DIV(CLK_DIV), .DEV_SEL(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ack_err(ack_err), .scl(scl), .sda(sda));

  always #5 clk = ~clk;
  pullup (sda);
  logic s_drv = 1'b0;
  bit slave_en = 1'b1;
  assign sda = s_drv ? 1'b0 : 1'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AT24C64 model, sampled mid-cycle so SCL/SDA edges are seen stable
  logic [7:0] mem [8192];
  logic [8:0] blog [$];
  logic ps = 1'b1, pd = 1'b1, act = 1'b0, snd = 1'b0, gsnd = 1'b0, mack = 1'b0;
  logic [7:0] sr = '0, txb = '0;
  logic [12:0] ptr = '0;
  int rc = 0, bno = 0;
  always @(negedge clk) begin
    if (slave_en) begin
      if (ps && scl && pd && !sda) begin
        act = 1'b1; rc = 0; bno = 0; snd = 1'b0; gsnd = 1'b0; s_drv = 1'b0;
        blog.push_back(9'h100);
      end else if (ps && scl && !pd && sda) begin
        act = 1'b0; s_drv = 1'b0;
      end else if (act && !ps && scl) begin
        if (!snd && rc < 8) sr = {sr[6:0], sda};
        if (snd && rc == 8) mack = sda;
        rc++;
      end else if (act && ps && !scl) begin
        if (rc == 8) begin
          s_drv = 1'b0;
          if (!snd) begin
            blog.push_back({1'b0, sr});
            if (bno == 0) begin
              s_drv = sr[7:1] == 7'b1010000;
              if (sr[0]) begin gsnd = 1'b1; txb = mem[ptr]; ptr = ptr + 13'd1; end
            end else if (bno == 1) ptr[12:8] = sr[4:0];
            else if (bno == 2) begin ptr[7:0] = sr; s_drv = 1'b1; end
            else begin mem[ptr] = sr; ptr = ptr + 13'd1; end
            if (bno == 1 || bno >= 3) s_drv = 1'b1;
            bno++;
          end
        end else if (rc == 9) begin
          rc = 0;
          s_drv = 1'b0;
          if (snd) begin snd = 1'b0; act = 1'b0; end
          else if (gsnd) begin snd = 1'b1; gsnd = 1'b0; s_drv = !txb[7]; end
        end else s_drv = snd && !txb[7-rc];
      end
    end
    ps = scl;
    pd = sda;
  end

  typedef struct packed {
    logic [7:0] rdata;
    logic aerr;
    logic [7:0] bits;
    logic [3:0] n;
    logic [5:0][8:0] bus;
  } exp_t;
  exp_t sb [$];

  function automatic exp_t mk(logic [7:0] rv, logic ae, int bits, int n,
                              logic [8:0] b0, b1, b2, b3, b4, b5);
    exp_t e;
    e.rdata = rv; e.aerr = ae; e.bits = 8'(bits); e.n = 4'(n);
    e.bus = {b5, b4, b3, b2, b1, b0};
    return e;
  endfunction

  int bcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else if (busy) bcnt++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done: got done=1 expected no transaction");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_err", ack_err, e.aerr);
        chk("rdata", rdata, e.rdata);
        chk("busy_cycles", bcnt, e.bits * BIT);
        chk("bus_len", blog.size(), e.n);
        for (int i = 0; i < int'(e.n) && i < blog.size(); i++) chk("bus_byte", blog[i], e.bus[i]);
      end
      blog.delete();
      bcnt = 0;
    end
  end

  task automatic wait_done();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout: got no done expected done within 5000 cycles");
  endtask

  task automatic issue(input logic rw, input logic [12:0] a, input logic [7:0] d, input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; wr_rd = rw; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    wait_done();
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_scl"}, scl, 1);
    chk({tag, "_sda"}, sda, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ack_err"}, ack_err, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8192; i++) mem[i] = 8'hFF;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_checks("reset");
    rst_n = 1'b1;
    issue(1'b0, 13'h0123, 8'hA5, mk(8'h00, 0, 38, 5, 9'h100, 9'h0A0, 9'h001, 9'h023, 9'h0A5, 9'h0));
    chk("mem_0123", mem[13'h0123], 8'hA5);
    issue(1'b1, 13'h0123, 8'h00, mk(8'hA5, 0, 48, 6, 9'h100, 9'h0A0, 9'h001, 9'h023, 9'h100, 9'h0A1));
    chk("master_nack", mack, 1);
    issue(1'b0, 13'h1FFF, 8'h3C, mk(8'hA5, 0, 38, 5, 9'h100, 9'h0A0, 9'h01F, 9'h0FF, 9'h03C, 9'h0));
    issue(1'b1, 13'h1FFF, 8'h00, mk(8'h3C, 0, 48, 6, 9'h100, 9'h0A0, 9'h01F, 9'h0FF, 9'h100, 9'h0A1));
    // req held high with a moving address: only the first capture counts
    sb.push_back(mk(8'h3C, 0, 38, 5, 9'h100, 9'h0A0, 9'h004, 9'h056, 9'h077, 9'h0));
    @(negedge clk);
    req = 1'b1; wr_rd = 1'b0; addr = 13'h0456; wdata = 8'h77;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      addr = addr + 13'd1;
      wdata = wdata + 8'd3;
    end
    req = 1'b0;
    n = 0;
    repeat (40) begin @(negedge clk); if (busy) n++; end
    chk("no_replay_busy", n, 0);
    chk("mem_0457", mem[13'h0457], 8'hFF);
    issue(1'b1, 13'h0456, 8'h00, mk(8'h77, 0, 48, 6, 9'h100, 9'h0A0, 9'h004, 9'h056, 9'h100, 9'h0A1));
    // abort a write during ADDR_L bit 3 (SDA driven low there for 8'h23)
    @(negedge clk);
    req = 1'b1; wr_rd = 1'b0; addr = 13'h0123; wdata = 8'hEE;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 2000 && blog.size() < 3; k++) @(negedge clk);
    chk("abort_reached_addr_l", blog.size(), 3);
    repeat (4 * BIT + 2) @(negedge clk);
    chk("abort_pre_sda", sda, 0);
    rst_n = 1'b0;
    #1 rst_checks("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    blog.delete();
    issue(1'b0, 13'h0000, 8'h5A, mk(8'h00, 0, 38, 5, 9'h100, 9'h0A0, 9'h000, 9'h000, 9'h05A, 9'h0));
    chk("mem_0123_kept", mem[13'h0123], 8'hA5);
    issue(1'b1, 13'h0000, 8'h00, mk(8'h5A, 0, 48, 6, 9'h100, 9'h0A0, 9'h000, 9'h000, 9'h100, 9'h0A1));
    // no slave on the bus: SDA floats high through every ACK slot
    slave_en = 1'b0;
    s_drv = 1'b0;
`ifdef ACK_CHECK_EN
    issue(1'b0, 13'h0055, 8'h11, mk(8'h5A, 1, 11, 0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0));
`else
    issue(1'b0, 13'h0055, 8'h11, mk(8'h5A, 0, 38, 0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0));
`endif
    repeat (4) @(negedge clk);
    chk("idle_scl", scl, 1);
    chk("idle_sda", sda, 1);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
